// File: rtl/kernel_ddr4_pipe_bridge.sv
// -----------------------------------------------------------------------------
// kernel_ddr4_pipe_bridge
//
// Registered Avalon-MM pipeline bridge. It sits between one kernel_ddr4 master
// port and its DDR4 controller slave. There is one instance per bank.
//
// Purpose:
//   - A 2-entry command skid buffer breaks the m_waitrequest -> s_waitrequest
//     path. s_waitrequest is taken straight from a flop.
//   - A 1-cycle response register breaks the readdata path.
//   - The bridge counts read beats in flight. It holds a read at the head of
//     the buffer until its whole burst fits under MAX_PENDING_READS, so the
//     controller response queue never overflows.
//
// Ports:
//   clock_reset_clk / clock_reset_reset_reset_n : clock, async active-low reset
//   s_*             : kernel-side slave (command in, read response out)
//   m_*             : controller-side master (command out, read response in)
//   pending_reads   : read beats accepted by the controller and not yet returned
//   rsp_underflow   : sticky, set when a response arrives with nothing pending
//
// Handshake rules:
//   - Kernel side: a command is taken on a clock edge where s_read or s_write
//     is high and s_waitrequest is low.
//   - Controller side: a command is taken on a clock edge where m_read or
//     m_write is high and m_waitrequest is low.
//   - The read data path has no backpressure. Every m_readdatavalid shows up
//     on s_readdatavalid exactly one cycle later.
// -----------------------------------------------------------------------------
module kernel_ddr4_pipe_bridge #(
    parameter int  ADDR_W            = 33,
    parameter int  DATA_W            = 512,
    parameter int  BE_W              = 64,
    parameter int  BURST_W           = 5,
    parameter int  MAX_PENDING_READS = 64,
    localparam int PEND_W            = $clog2(MAX_PENDING_READS + 1)
) (
    input  logic               clock_reset_clk,
    input  logic               clock_reset_reset_reset_n,
    input  logic [ADDR_W-1:0]  s_address,
    input  logic [BE_W-1:0]    s_byteenable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [DATA_W-1:0]  s_writedata,
    input  logic [BURST_W-1:0] s_burstcount,
    output logic               s_waitrequest,
    output logic [DATA_W-1:0]  s_readdata,
    output logic               s_readdatavalid,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BE_W-1:0]    m_byteenable,
    output logic               m_read,
    output logic               m_write,
    output logic [DATA_W-1:0]  m_writedata,
    output logic [BURST_W-1:0] m_burstcount,
    input  logic               m_waitrequest,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_readdatavalid,
    output logic [PEND_W-1:0]  pending_reads,
    output logic               rsp_underflow
);

    // The sum is wide enough to hold pending count plus one burst without
    // wrapping.
    localparam int SUM_W = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  address;
        logic [BE_W-1:0]    byteenable;
        logic [DATA_W-1:0]  writedata;
        logic               read;
        logic               write;
        logic [BURST_W-1:0] burstcount;
    } cmd_t;

    cmd_t              fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              s_waitrequest_q;
    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;
    logic              underflow_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    cmd_t              head;
    cmd_t              push_cmd;
    logic              head_valid;
    logic              push;
    logic              pop;
    logic              rd_accept;
    logic              rsp_dec;
    logic              read_throttled;
    logic [SUM_W-1:0]  read_need;
    logic [SUM_W-1:0]  pending_sum;

    assign head       = fifo_q[rd_ptr_q];
    assign head_valid = (count_q != 2'd0);
    assign push_cmd   = {s_address, s_byteenable, s_writedata, s_read, s_write, s_burstcount};
    assign push       = (s_read | s_write) & ~s_waitrequest_q;

    // While a read waits at the head, pending_reads can only go down, because
    // nothing else is issued. So once the read has been presented it stays
    // presented, and the outputs hold steady under m_waitrequest.
    assign read_need      = SUM_W'(pending_q) + SUM_W'(head.burstcount);
    assign read_throttled = (read_need > SUM_W'(MAX_PENDING_READS));

    assign m_read    = head_valid & head.read & ~read_throttled;
    assign m_write   = head_valid & head.write;
    assign pop       = (m_read | m_write) & ~m_waitrequest;
    assign rd_accept = m_read & ~m_waitrequest;

    // A response that arrives with nothing pending is still forwarded, but it
    // is not counted. That keeps the counter from wrapping below zero.
    assign rsp_dec = m_readdatavalid & (pending_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end

        pending_sum = SUM_W'(pending_q);
        if (rd_accept) begin
            pending_sum = pending_sum + SUM_W'(head.burstcount);
        end
        if (rsp_dec) begin
            pending_sum = pending_sum - SUM_W'(1);
        end
        pending_d = pending_sum[PEND_W-1:0];
    end

    always_ff @(posedge clock_reset_clk or negedge clock_reset_reset_reset_n) begin
        if (!clock_reset_reset_reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            s_waitrequest_q <= 1'b1;
            pending_q       <= '0;
            underflow_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_cmd;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            // The buffer is full next cycle. This covers "2 entries" and also
            // "1 entry with a push and no pop".
            s_waitrequest_q <= (count_d == 2'd2);
            pending_q       <= pending_d;
            underflow_q     <= underflow_q | (m_readdatavalid & (pending_q == '0));
            rsp_valid_q     <= m_readdatavalid;
            if (m_readdatavalid) begin
                rsp_data_q <= m_readdata;
            end
        end
    end

    assign s_waitrequest   = s_waitrequest_q;
    assign s_readdatavalid = rsp_valid_q;
    assign s_readdata      = rsp_data_q;
    assign m_address       = head.address;
    assign m_byteenable    = head.byteenable;
    assign m_writedata     = head.writedata;
    assign m_burstcount    = head.burstcount;
    assign pending_reads   = pending_q;
    assign rsp_underflow   = underflow_q;

endmodule
